// File: rtl/zeus_bus_pkg.sv
// Shared Zeus CPU-bus definitions: write target encoding and chip-select decode.
package zeus_bus_pkg;

    localparam int unsigned BUS_W = 8;
    localparam int unsigned SEL_W = 6;

    typedef enum logic [2:0] {
        TGT_NONE,
        TGT_VIDEO,
        TGT_IRQ,
        TGT_SPI,
        TGT_MMU,
        TGT_RAM,
        TGT_VRAM,
        TGT_MULTI
    } bus_target_t;

    // sel_n bit order: [0]video [1]irq [2]spi [3]mmu [4]ram [5]vram, all active-low
    function automatic bus_target_t decode_sel(input logic [SEL_W-1:0] sel_n);
        int unsigned n_low;
        bus_target_t t;
        n_low = 0;
        t     = TGT_NONE;
        for (int unsigned i = 0; i < SEL_W; i++) begin
            if (!sel_n[i]) n_low++;
        end
        if (n_low > 1)      t = TGT_MULTI;
        else if (!sel_n[0]) t = TGT_VIDEO;
        else if (!sel_n[1]) t = TGT_IRQ;
        else if (!sel_n[2]) t = TGT_SPI;
        else if (!sel_n[3]) t = TGT_MMU;
        else if (!sel_n[4]) t = TGT_RAM;
        else if (!sel_n[5]) t = TGT_VRAM;
        return t;
    endfunction

endpackage

// File: rtl/vram_write_fifo.sv
// Posted-write FIFO of {data, addr} for the VRAM valid/ready port.
// Only built when DATA_BUS_WRITER_VRAM_FIFO_EN is defined.
`ifdef DATA_BUS_WRITER_VRAM_FIFO_EN
import zeus_bus_pkg::*;

module vram_write_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [BUS_W-1:0]           i_data,
    input  logic [BUS_W-1:0]           i_addr,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [BUS_W-1:0]           o_data,
    output logic [BUS_W-1:0]           o_addr,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [2*BUS_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_pop;
    logic               w_push_ok;

    assign o_valid    = (r_count != '0);
    assign w_pop      = i_pop && o_valid;
    // A pop in the same clk frees the slot, so a push into a full FIFO is legal then
    assign w_push_ok  = i_push && ((r_count != CNT_FULL) || w_pop);
    assign o_overflow = i_push && !w_push_ok;
    assign {o_data, o_addr} = r_mem[r_rd_ptr];
    assign o_count    = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= {i_data, i_addr};
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_push_ok && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (w_pop && !w_push_ok) r_count <= r_count - CNT_ONE;
        end
    end

endmodule
`endif

// File: rtl/data_bus_writer.sv
// Captures CPU writes on the phi2 falling edge and issues one-clk target strobes or VRAM posts.
// DATA_BUS_WRITER_VRAM_FIFO_EN selects a posted FIFO for VRAM instead of a single holding register.
import zeus_bus_pkg::*;

module data_bus_writer #(
    parameter int unsigned VRAM_FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             phi2,
    input  logic             read_write,
    input  logic [BUS_W-1:0] cpu_data_bus,
    input  logic [BUS_W-1:0] reg_addr,
    input  logic             io_video_n,
    input  logic             io_irq_n,
    input  logic             io_spi_n,
    input  logic             io_mmu_n,
    input  logic             ram_cs_n,
    input  logic             vram_cs_n,
    output logic [BUS_W-1:0] wr_data,
    output logic [BUS_W-1:0] wr_addr,
    output logic             video_we,
    output logic             irq_we,
    output logic             spi_we,
    output logic             mmu_we,
    output logic             ram_we,
    output logic             vram_wr_valid,
    input  logic             vram_wr_ready,
    output logic [BUS_W-1:0] vram_wr_data,
    output logic [BUS_W-1:0] vram_wr_addr,
    output logic             cpu_rdy,
    output logic             multi_sel_err
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STROBE = 1'b1;

    if (VRAM_FIFO_DEPTH < 2 || VRAM_FIFO_DEPTH > 16 ||
        (VRAM_FIFO_DEPTH & (VRAM_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("VRAM_FIFO_DEPTH must be a power of two in 2..16");
    end

    logic             r_phi2_q;
    logic [0:0]       r_state;
    bus_target_t      r_target;
    logic [BUS_W-1:0] r_wr_data;
    logic [BUS_W-1:0] r_wr_addr;
    logic             r_multi_err;
    logic             w_capture;
    logic             w_strobe;
    logic             w_vram_push;
    logic             w_overflow;
    bus_target_t      w_sel_target;

    assign w_capture    = r_phi2_q && !phi2 && !read_write;
    assign w_sel_target = decode_sel({vram_cs_n, ram_cs_n, io_mmu_n, io_spi_n, io_irq_n, io_video_n});
    assign w_strobe     = (r_state == ST_STROBE);
    assign w_vram_push  = w_strobe && (r_target == TGT_VRAM);

    assign video_we      = w_strobe && (r_target == TGT_VIDEO);
    assign irq_we        = w_strobe && (r_target == TGT_IRQ);
    assign spi_we        = w_strobe && (r_target == TGT_SPI);
    assign mmu_we        = w_strobe && (r_target == TGT_MMU);
    assign ram_we        = w_strobe && (r_target == TGT_RAM);
    assign wr_data       = r_wr_data;
    assign wr_addr       = r_wr_addr;
    assign multi_sel_err = r_multi_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phi2_q    <= 1'b0;
            r_state     <= ST_IDLE;
            r_target    <= TGT_NONE;
            r_wr_data   <= '0;
            r_wr_addr   <= '0;
            r_multi_err <= 1'b0;
        end else begin
            r_phi2_q <= phi2;
            if (w_capture) begin
                r_wr_data <= cpu_data_bus;
                r_wr_addr <= reg_addr;
                r_target  <= w_sel_target;
                r_state   <= ST_STROBE;
            end else begin
                r_state <= ST_IDLE;
            end
            if ((w_capture && w_sel_target == TGT_MULTI) || w_overflow) r_multi_err <= 1'b1;
        end
    end

`ifdef DATA_BUS_WRITER_VRAM_FIFO_EN
    logic [$clog2(VRAM_FIFO_DEPTH+1)-1:0] w_fifo_count;

    vram_write_fifo #(
        .DEPTH(VRAM_FIFO_DEPTH)
    ) u_vram_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_vram_push),
        .i_data    (r_wr_data),
        .i_addr    (r_wr_addr),
        .i_pop     (vram_wr_ready),
        .o_valid   (vram_wr_valid),
        .o_data    (vram_wr_data),
        .o_addr    (vram_wr_addr),
        .o_count   (w_fifo_count),
        .o_overflow(w_overflow)
    );

    // One slot is kept back for a write that may already be captured but not yet pushed
    assign cpu_rdy = (32'(w_fifo_count) < VRAM_FIFO_DEPTH - 1);
`else
    logic             r_hold_valid;
    logic [BUS_W-1:0] r_hold_data;
    logic [BUS_W-1:0] r_hold_addr;
    logic             r_xfer_q;
    logic             w_xfer;

    assign w_xfer     = r_hold_valid && vram_wr_ready;
    assign w_overflow = w_vram_push && r_hold_valid && !vram_wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_hold_addr  <= '0;
            r_xfer_q     <= 1'b0;
        end else begin
            r_xfer_q <= w_xfer;
            if (w_vram_push && (!r_hold_valid || vram_wr_ready)) begin
                r_hold_valid <= 1'b1;
                r_hold_data  <= r_wr_data;
                r_hold_addr  <= r_wr_addr;
            end else if (w_xfer) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    assign vram_wr_valid = r_hold_valid;
    assign vram_wr_data  = r_hold_data;
    assign vram_wr_addr  = r_hold_addr;
    assign cpu_rdy       = !(r_hold_valid || r_xfer_q);
`endif

endmodule

// File: tb/tb_data_bus_writer.sv
// Directed bench for data_bus_writer: table of single bus writes plus VRAM and reset sequences.
module tb_data_bus_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       phi2;
    logic       read_write;
    logic [7:0] cpu_data_bus;
    logic [7:0] reg_addr;
    logic       io_video_n, io_irq_n, io_spi_n, io_mmu_n, ram_cs_n, vram_cs_n;
    logic [7:0] wr_data, wr_addr;
    logic       video_we, irq_we, spi_we, mmu_we, ram_we;
    logic       vram_wr_valid, vram_wr_ready;
    logic [7:0] vram_wr_data, vram_wr_addr;
    logic       cpu_rdy, multi_sel_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    localparam logic [5:0] S_NONE  = 6'b111111;
    localparam logic [5:0] S_VIDEO = 6'b111110;
    localparam logic [5:0] S_IRQ   = 6'b111101;
    localparam logic [5:0] S_SPI   = 6'b111011;
    localparam logic [5:0] S_MMU   = 6'b110111;
    localparam logic [5:0] S_RAM   = 6'b101111;
    localparam logic [5:0] S_VRAM  = 6'b011111;
    localparam logic [5:0] S_MULTI = 6'b100111;

    data_bus_writer #(
        .VRAM_FIFO_DEPTH(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .phi2         (phi2),
        .read_write   (read_write),
        .cpu_data_bus (cpu_data_bus),
        .reg_addr     (reg_addr),
        .io_video_n   (io_video_n),
        .io_irq_n     (io_irq_n),
        .io_spi_n     (io_spi_n),
        .io_mmu_n     (io_mmu_n),
        .ram_cs_n     (ram_cs_n),
        .vram_cs_n    (vram_cs_n),
        .wr_data      (wr_data),
        .wr_addr      (wr_addr),
        .video_we     (video_we),
        .irq_we       (irq_we),
        .spi_we       (spi_we),
        .mmu_we       (mmu_we),
        .ram_we       (ram_we),
        .vram_wr_valid(vram_wr_valid),
        .vram_wr_ready(vram_wr_ready),
        .vram_wr_data (vram_wr_data),
        .vram_wr_addr (vram_wr_addr),
        .cpu_rdy      (cpu_rdy),
        .multi_sel_err(multi_sel_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [7:0] data;
        logic [7:0] addr;
        logic [5:0] sel_n;
        logic [4:0] exp_we;
        logic       chk_data;
        logic [7:0] exp_data;
        logic [7:0] exp_addr;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [4:0] we_vec();
        return {ram_we, mmu_we, spi_we, irq_we, video_we};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_sel(input logic [5:0] s);
        {vram_cs_n, ram_cs_n, io_mmu_n, io_spi_n, io_irq_n, io_video_n} = s;
    endtask

    // Drives the bus with phi2 high for one clk, then drops phi2; the next clk edge is the falling-edge clk.
    task automatic bus_start(input logic rw, input logic [7:0] d, input logic [7:0] a, input logic [5:0] s);
        phi2         = 1'b1;
        read_write   = rw;
        cpu_data_bus = d;
        reg_addr     = a;
        set_sel(s);
        tick();
        phi2 = 1'b0;
    endtask

    task automatic bus_release();
        read_write = 1'b1;
        set_sel(S_NONE);
    endtask

    task automatic vram_write(input logic [7:0] d, input logic [7:0] a);
        bus_start(1'b0, d, a, S_VRAM);
        tick();
        chk("vram_no_strobe", {27'd0, we_vec()}, 32'd0);
        tick();
        bus_release();
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'h5A, 8'h03, S_SPI,   5'b00100, 1'b1, 8'h5A, 8'h03, 1'b0};
        vecs[1] = '{1'b0, 8'hA5, 8'h00, S_VIDEO, 5'b00001, 1'b1, 8'hA5, 8'h00, 1'b0};
        vecs[2] = '{1'b0, 8'h01, 8'h10, S_IRQ,   5'b00010, 1'b1, 8'h01, 8'h10, 1'b0};
        vecs[3] = '{1'b0, 8'hFF, 8'h7F, S_MMU,   5'b01000, 1'b1, 8'hFF, 8'h7F, 1'b0};
        vecs[4] = '{1'b0, 8'h3C, 8'hC0, S_RAM,   5'b10000, 1'b1, 8'h3C, 8'hC0, 1'b0};
        vecs[5] = '{1'b1, 8'h66, 8'h44, S_IRQ,   5'b00000, 1'b1, 8'h3C, 8'hC0, 1'b0};
        vecs[6] = '{1'b0, 8'h77, 8'h55, S_NONE,  5'b00000, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[7] = '{1'b0, 8'h88, 8'h66, S_MULTI, 5'b00000, 1'b0, 8'h00, 8'h00, 1'b1};

        reset         = 1'b1;
        phi2          = 1'b0;
        read_write    = 1'b1;
        cpu_data_bus  = 8'h00;
        reg_addr      = 8'h00;
        vram_wr_ready = 1'b0;
        set_sel(S_NONE);
        repeat (3) tick();
        chk("rst_we",    {27'd0, we_vec()}, 32'd0);
        chk("rst_valid", {31'd0, vram_wr_valid}, 32'd0);
        chk("rst_rdy",   {31'd0, cpu_rdy}, 32'd1);
        chk("rst_err",   {31'd0, multi_sel_err}, 32'd0);
        chk("rst_data",  {24'd0, wr_data}, 32'd0);
        chk("rst_addr",  {24'd0, wr_addr}, 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            bus_start(vecs[i].rw, vecs[i].data, vecs[i].addr, vecs[i].sel_n);
            chk($sformatf("v%0d_we_before", i), {27'd0, we_vec()}, 32'd0);
            tick();
            chk($sformatf("v%0d_we", i), {27'd0, we_vec()}, {27'd0, vecs[i].exp_we});
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_data", i), {24'd0, wr_data}, {24'd0, vecs[i].exp_data});
                chk($sformatf("v%0d_addr", i), {24'd0, wr_addr}, {24'd0, vecs[i].exp_addr});
            end
            tick();
            bus_release();
            chk($sformatf("v%0d_we_after", i), {27'd0, we_vec()}, 32'd0);
            chk($sformatf("v%0d_err", i), {31'd0, multi_sel_err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_vvalid", i), {31'd0, vram_wr_valid}, 32'd0);
        end

        repeat (4) tick();
        chk("err_sticky", {31'd0, multi_sel_err}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("err_cleared", {31'd0, multi_sel_err}, 32'd0);

`ifdef DATA_BUS_WRITER_VRAM_FIFO_EN
        begin
            logic [7:0] fd [3];
            fd[0] = 8'h11; fd[1] = 8'h22; fd[2] = 8'h33;
            for (int i = 0; i < 3; i++) begin
                vram_write(fd[i], 8'(8'h01 + i));
                chk($sformatf("f%0d_valid", i), {31'd0, vram_wr_valid}, 32'd1);
                chk($sformatf("f%0d_rdy", i), {31'd0, cpu_rdy}, (i < 2) ? 32'd1 : 32'd0);
            end
            vram_wr_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("f_out%0d_valid", i), {31'd0, vram_wr_valid}, 32'd1);
                chk($sformatf("f_out%0d_data", i), {24'd0, vram_wr_data}, {24'd0, fd[i]});
                chk($sformatf("f_out%0d_addr", i), {24'd0, vram_wr_addr}, 32'(8'h01 + i));
                tick();
            end
            vram_wr_ready = 1'b0;
            chk("f_empty_valid", {31'd0, vram_wr_valid}, 32'd0);
            chk("f_empty_rdy",   {31'd0, cpu_rdy}, 32'd1);
            vram_write(8'hA1, 8'h30);
            vram_write(8'hA2, 8'h31);
            chk("f_rst_pending", {31'd0, vram_wr_valid}, 32'd1);
        end
`else
        chk("h_rdy_idle", {31'd0, cpu_rdy}, 32'd1);
        vram_write(8'h99, 8'h20);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("h_valid%0d", k), {31'd0, vram_wr_valid}, 32'd1);
            chk($sformatf("h_data%0d", k),  {24'd0, vram_wr_data}, 32'h99);
            chk($sformatf("h_addr%0d", k),  {24'd0, vram_wr_addr}, 32'h20);
            chk($sformatf("h_rdy%0d", k),   {31'd0, cpu_rdy}, 32'd0);
            tick();
        end
        vram_wr_ready = 1'b1;
        tick();
        vram_wr_ready = 1'b0;
        chk("h_valid_after_xfer", {31'd0, vram_wr_valid}, 32'd0);
        chk("h_rdy_after_xfer",   {31'd0, cpu_rdy}, 32'd0);
        tick();
        chk("h_rdy_released",     {31'd0, cpu_rdy}, 32'd1);
        vram_write(8'hA1, 8'h30);
        chk("h_rst_pending", {31'd0, vram_wr_valid}, 32'd1);
`endif

        bus_start(1'b0, 8'h42, 8'h31, S_SPI);
        tick();
        chk("rst_mid_strobe", {31'd0, spi_we}, 32'd1);
        reset = 1'b1;
        tick();
        chk("rst_mid_we",    {27'd0, we_vec()}, 32'd0);
        chk("rst_mid_valid", {31'd0, vram_wr_valid}, 32'd0);
        chk("rst_mid_rdy",   {31'd0, cpu_rdy}, 32'd1);
        reset = 1'b0;
        bus_release();
        tick();
        chk("rst_post_we",    {27'd0, we_vec()}, 32'd0);
        chk("rst_post_valid", {31'd0, vram_wr_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
